multi_divider: RTL and testbench

Multi-channel programmable clock divider. It is the successor to the single-channel variable divider.
- Each channel produces a divided waveform with a programmable divisor and a programmable high time.
- Each channel also produces a one-cycle period-start tick.
- Divisor and high-time updates are shadowed and applied only at period boundaries, so the output never shows a runt pulse.
- Single clock domain, rising edge only. Outputs are registered and meant to drive clock-enable or display/scan logic, not clock trees.

---
 rtl/multi_divider_pkg.sv | 17 +
 rtl/multi_divider_channel.sv | 105 ++++++++++
 rtl/multi_divider.sv | 46 ++++
 tb/tb_multi_divider.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_divider_pkg.sv
// Shared helpers for the multi-channel clock divider.
// Optional phase offsets are enabled with MULTI_DIVIDER_PHASE_EN.
package multi_divider_pkg;

  localparam int MAX_WIDTH = 32;

  typedef logic [MAX_WIDTH-1:0] word_t;

  function automatic word_t eff_divisor(input word_t div);
    return (div < word_t'(2)) ? word_t'(1) : div;
  endfunction

  function automatic word_t eff_high(input word_t high, input word_t d);
    return (high > d) ? d : high;
  endfunction

endpackage

// File: rtl/multi_divider_channel.sv
// One divider channel: shadow/active registers, counter, output flops.
// Phase start offset is fed from the top (zero unless MULTI_DIVIDER_PHASE_EN).
module divider_channel
  import multi_divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] high_time,
  input  logic [WIDTH-1:0] phase,
  output logic             clock_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] high_a_q, high_a_d;
  logic [WIDTH-1:0] div_s_q, div_s_d;
  logic [WIDTH-1:0] high_s_q, high_s_d;
  logic             pend_q, pend_d;
  logic             en_q;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] d_cur, d_nxt, h_nxt;
  logic             bnd;

  assign d_cur = WIDTH'(eff_divisor(word_t'(div_a_q)));
  assign bnd   = !enable || !en_q || (cnt_q == d_cur - ONE);

  // Active values only change where no period is in flight.
  always_comb begin
    div_s_d  = div_s_q;
    high_s_d = high_s_q;
    div_a_d  = div_a_q;
    high_a_d = high_a_q;
    pend_d   = pend_q;
    if (load) begin
      div_s_d  = divisor;
      high_s_d = high_time;
    end
    if (bnd) begin
      if (load || pend_q) begin
        div_a_d  = div_s_d;
        high_a_d = high_s_d;
      end
      pend_d = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end
  end

  assign d_nxt = WIDTH'(eff_divisor(word_t'(div_a_d)));
  assign h_nxt = WIDTH'(eff_high(word_t'(high_a_d), word_t'(d_nxt)));

  always_comb begin
    cnt_d = cnt_q;
    if (!enable) begin
      cnt_d = '0;
    end else if (!en_q) begin
      cnt_d = (phase > d_nxt - ONE) ? d_nxt - ONE : phase;
    end else if (cnt_q == d_cur - ONE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
    clk_d  = enable && (cnt_d < h_nxt);
    tick_d = enable && (cnt_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      div_a_q  <= '0;
      high_a_q <= '0;
      div_s_q  <= '0;
      high_s_q <= '0;
      pend_q   <= 1'b0;
      en_q     <= 1'b0;
      clk_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_a_q  <= div_a_d;
      high_a_q <= high_a_d;
      div_s_q  <= div_s_d;
      high_s_q <= high_s_d;
      pend_q   <= pend_d;
      en_q     <= enable;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
    end
  end

  assign clock_out = clk_q;
  assign tick      = tick_q;
  assign pending   = pend_q;

endmodule

// File: rtl/multi_divider.sv
// Multi-channel programmable clock divider top.
// Define MULTI_DIVIDER_PHASE_EN to add per-channel start phase input.
module multi_divider
  import multi_divider_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] divisor,
  input  logic [CHANNELS*WIDTH-1:0] high_time,
`ifdef MULTI_DIVIDER_PHASE_EN
  input  logic [CHANNELS*WIDTH-1:0] phase,
`endif
  output logic [CHANNELS-1:0]       clock_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pending
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] ph;
`ifdef MULTI_DIVIDER_PHASE_EN
    assign ph = phase[i*WIDTH +: WIDTH];
`else
    assign ph = '0;
`endif
    divider_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (enable[i]),
      .load     (load[i]),
      .divisor  (divisor[i*WIDTH +: WIDTH]),
      .high_time(high_time[i*WIDTH +: WIDTH]),
      .phase    (ph),
      .clock_out(clock_out[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_multi_divider.sv
// Scoreboard bench for multi_divider.
// Phase checks follow MULTI_DIVIDER_PHASE_EN.
module tb_multi_divider;

  localparam int CH = 4;
  localparam int W  = 16;
`ifdef MULTI_DIVIDER_PHASE_EN
  localparam bit PH_EN = 1'b1;
`else
  localparam bit PH_EN = 1'b0;
`endif

  logic            clock;
  logic            reset_n;
  logic [CH-1:0]   en;
  logic [CH-1:0]   ld;
  logic [CH*W-1:0] dv;
  logic [CH*W-1:0] hv;
  logic [CH*W-1:0] ph;
  logic [CH-1:0]   clock_out;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   pending;

  int checks   = 0;
  int failures = 0;

  logic [3*CH-1:0] sbq[$];

  int m_cnt[CH];
  int m_da[CH];
  int m_ha[CH];
  int m_ds[CH];
  int m_hs[CH];
  bit m_pd[CH];
  bit m_en[CH];

  multi_divider #(
    .CHANNELS(CH),
    .WIDTH   (W)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (en),
    .load     (ld),
    .divisor  (dv),
    .high_time(hv),
`ifdef MULTI_DIVIDER_PHASE_EN
    .phase    (ph),
`endif
    .clock_out(clock_out),
    .tick     (tick),
    .pending  (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    sbq.delete();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_da[i] = 0; m_ha[i] = 0;
      m_ds[i] = 0;  m_hs[i] = 0; m_pd[i] = 0; m_en[i] = 0;
    end
  endtask

  function automatic int effd(input int d);
    return (d < 2) ? 1 : d;
  endfunction

  task automatic mdl_step();
    logic [3*CH-1:0] e;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      int dcur, dn, hn, vd, vh, pv;
      vd = int'(dv[i*W +: W]);
      vh = int'(hv[i*W +: W]);
      pv = int'(ph[i*W +: W]);
      dcur = effd(m_da[i]);
      if (!en[i] || !m_en[i] || m_cnt[i] == dcur - 1) begin
        if (ld[i]) begin
          m_da[i] = vd; m_ha[i] = vh;
        end else if (m_pd[i]) begin
          m_da[i] = m_ds[i]; m_ha[i] = m_hs[i];
        end
        m_pd[i] = 0;
      end else if (ld[i]) begin
        m_pd[i] = 1;
      end
      if (ld[i]) begin
        m_ds[i] = vd; m_hs[i] = vh;
      end
      dn = effd(m_da[i]);
      hn = (m_ha[i] > dn) ? dn : m_ha[i];
      if (!en[i]) m_cnt[i] = 0;
      else if (!m_en[i]) m_cnt[i] = PH_EN ? ((pv > dn - 1) ? dn - 1 : pv) : 0;
      else if (m_cnt[i] == dcur - 1) m_cnt[i] = 0;
      else m_cnt[i] = m_cnt[i] + 1;
      m_en[i] = en[i];
      e[2*CH + i] = en[i] && (m_cnt[i] < hn);
      e[CH + i]   = en[i] && (m_cnt[i] == 0);
      e[i]        = m_pd[i];
    end
    sbq.push_back(e);
  endtask

  task automatic cyc();
    logic [3*CH-1:0] e;
    mdl_step();
    @(posedge clock);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk("cyc", 32'({clock_out, tick, pending}), 32'(e));
    end
  endtask

  task automatic set_ch(input int i, input int d, input int h);
    dv[i*W +: W] = W'(d);
    hv[i*W +: W] = W'(h);
  endtask

  task automatic load(input logic [CH-1:0] m);
    ld = m;
    cyc();
    ld = '0;
  endtask

  initial begin
    logic [4:0] pat5;
    logic [5:0] pat6;
    int         t1;
    pat5 = 5'b00011;
    pat6 = 6'b000111;
    reset_n = 1'b0;
    en = '0; ld = '0; dv = '0; hv = '0; ph = '0;
    mdl_reset();
    repeat (2) @(posedge clock);
    #1;
    en = '1;
    chk("rst_hold", 32'({clock_out, tick, pending}), 32'd0);
    reset_n = 1'b1;
    chk("rst_rel", 32'({clock_out, tick, pending}), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_tick", 32'(tick), 32'hF);
      chk("rst_clk", 32'(clock_out), 32'h0);
    end

    en[0] = 1'b0;
    set_ch(0, 5, 2);
    load(4'b0001);
    en[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("div5_clk", 32'(clock_out[0]), 32'(pat5[k % 5]));
      chk("div5_tick", 32'(tick[0]), 32'(k % 5 == 0));
    end

    en[0] = 1'b0;
    set_ch(0, 0, 1);
    load(4'b0001);
    en[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("div0_tick", 32'(tick[0]), 32'd1);
      chk("div0_clk", 32'(clock_out[0]), 32'd1);
    end
    en[0] = 1'b0;
    set_ch(0, 1, 0);
    load(4'b0001);
    en[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("div1_tick", 32'(tick[0]), 32'd1);
      chk("div1_clk", 32'(clock_out[0]), 32'd0);
    end

    en[1] = 1'b0;
    set_ch(1, 4, 2);
    load(4'b0010);
    en[1] = 1'b1;
    cyc();
    cyc();
    set_ch(1, 6, 3);
    load(4'b0010);
    chk("upd_pend2", 32'(pending[1]), 32'd1);
    cyc();
    chk("upd_pend3", 32'(pending[1]), 32'd1);
    chk("upd_old_clk", 32'(clock_out[1]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("upd_clk", 32'(clock_out[1]), 32'(pat6[k]));
      chk("upd_pend", 32'(pending[1]), 32'd0);
    end
    set_ch(1, 4, 1);
    load(4'b0010);
    chk("bnd_tick", 32'(tick[1]), 32'd1);
    chk("bnd_clk", 32'(clock_out[1]), 32'd1);
    chk("bnd_pend", 32'(pending[1]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bnd_low", 32'({clock_out[1], tick[1]}), 32'd0);
    end
    cyc();
    chk("bnd_wrap", 32'({clock_out[1], tick[1]}), 32'd3);

    en[2] = 1'b0;
    set_ch(2, 5, 2);
    load(4'b0100);
    en[2] = 1'b1;
    cyc();
    cyc();
    set_ch(2, 3, 2);
    load(4'b0100);
    set_ch(2, 7, 1);
    load(4'b0100);
    cyc();
    chk("lw_pend", 32'(pending[2]), 32'd1);
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("lw_tick", 32'(tick[2]), 32'(k == 0));
      chk("lw_clk", 32'(clock_out[2]), 32'(k == 0));
    end
    cyc();
    chk("lw_wrap", 32'(tick[2]), 32'd1);

    en[3] = 1'b0;
    set_ch(3, 4, 0);
    load(4'b1000);
    en[3] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("h0_clk", 32'(clock_out[3]), 32'd0);
      chk("h0_tick", 32'(tick[3]), 32'(k % 4 == 0));
    end
    en[3] = 1'b0;
    set_ch(3, 4, 9);
    load(4'b1000);
    en[3] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("h9_clk", 32'(clock_out[3]), 32'd1);
    end

    en[1:0] = 2'b00;
    set_ch(0, 8, 4);
    set_ch(1, 8, 4);
    ph[0*W +: W] = W'(0);
    ph[1*W +: W] = W'(4);
    load(4'b0011);
    en[1:0] = 2'b11;
    t1 = -1;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (t1 < 0 && tick[1]) t1 = k;
      chk("ph_rel", 32'(clock_out[0] ^ clock_out[1]), 32'(PH_EN));
    end
    chk("ph_tick1", 32'(t1), PH_EN ? 32'd4 : 32'd0);

    set_ch(3, 5, 2);
    load(4'b1000);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst", 32'({clock_out, tick, pending}), 32'd0);
    mdl_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    chk("post_rst_tick", 32'(tick), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
